// File: rtl/rm_lane_release_if.sv
// Bundle of the allocator, commit, lane-done and release signals of
// rm_lane_release. The master side drives the pipeline events; the slave
// side (the release controller) returns pulses, busy count and error flag.
interface rm_lane_release_if #(
  parameter int NUM_LANES       = 4,
  parameter int NUM_EVENTS      = 2,
  parameter int NR_COMMIT_PORTS = 2
);
  localparam int LW = (NUM_LANES  > 1) ? $clog2(NUM_LANES)  : 1;
  localparam int EW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int NL = NUM_EVENTS * NUM_LANES;
  localparam int CW = $clog2(NL + 1);
  localparam int P  = NR_COMMIT_PORTS;

  logic            flush_i;
  logic            alloc_valid_i;
  logic [EW-1:0]   alloc_event_i;
  logic [LW-1:0]   alloc_lane_i;
  logic [P-1:0]    commit_ack_i;
  logic [P-1:0]    commit_rm_valid_i;
  logic [P*EW-1:0] commit_event_i;
  logic [P*LW-1:0] commit_lane_i;
  logic [NL-1:0]   lane_done_i;
  logic [NL-1:0]   reset_monitor_o;
  logic [CW-1:0]   busy_cnt_o;
  logic            err_o;

  modport master (
    output flush_i, alloc_valid_i, alloc_event_i, alloc_lane_i,
           commit_ack_i, commit_rm_valid_i, commit_event_i, commit_lane_i,
           lane_done_i,
    input  reset_monitor_o, busy_cnt_o, err_o
  );

  modport slave (
    input  flush_i, alloc_valid_i, alloc_event_i, alloc_lane_i,
           commit_ack_i, commit_rm_valid_i, commit_event_i, commit_lane_i,
           lane_done_i,
    output reset_monitor_o, busy_cnt_o, err_o
  );
endinterface

// File: rtl/rm_lane_release.sv
// Release controller for runtime-monitor lanes. Each (event, lane) pair has
// its own small FSM that tracks allocation, the lane's own completion and the
// commit of the owning instruction, and emits a one-cycle release pulse once
// both have happened (or the lane is flushed before commit). A registered
// busy count and a sticky protocol-error flag are also provided.
module rm_lane_release #(
  parameter int NUM_LANES       = 4,
  parameter int NUM_EVENTS      = 2,
  parameter int NR_COMMIT_PORTS = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  rm_lane_release_if.slave bus
);
  localparam int LW = (NUM_LANES  > 1) ? $clog2(NUM_LANES)  : 1;
  localparam int EW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int NL = NUM_EVENTS * NUM_LANES;
  localparam int CW = $clog2(NL + 1);
  localparam int P  = NR_COMMIT_PORTS;

  typedef enum logic [2:0] {
    S_FREE       = 3'd0,
    S_ALLOC      = 3'd1,
    S_DONE_EARLY = 3'd2,
    S_COMMITTED  = 3'd3,
    S_RELEASE    = 3'd4
  } state_e;

  state_e        r_state [NL];
  state_e        w_next  [NL];
  logic [NL-1:0] w_commit_hit;
  logic [NL-1:0] w_commit_multi;
  logic [NL-1:0] w_alloc_hit;
  logic [NL-1:0] w_lane_err;
  logic [NL-1:0] w_release_nxt;
  logic [CW-1:0] w_busy_nxt;
  logic          w_err_nxt;
  logic [NL-1:0] r_reset_monitor;
  logic [CW-1:0] r_busy_cnt;
  logic          r_err;

  // Decode commit ports and the allocator into per-lane strobes; a second
  // port hitting the same lane is folded into the first and flagged.
  always_comb begin
    w_commit_hit   = '0;
    w_commit_multi = '0;
    w_alloc_hit    = '0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int p = 0; p < P; p++) begin
          if (bus.commit_ack_i[p] && bus.commit_rm_valid_i[p] &&
              (bus.commit_event_i[p*EW +: EW] == EW'(e)) &&
              (bus.commit_lane_i[p*LW +: LW] == LW'(l))) begin
            if (w_commit_hit[e*NUM_LANES + l]) begin
              w_commit_multi[e*NUM_LANES + l] = 1'b1;
            end
            w_commit_hit[e*NUM_LANES + l] = 1'b1;
          end
        end
        if (bus.alloc_valid_i && !bus.flush_i &&
            (bus.alloc_event_i == EW'(e)) && (bus.alloc_lane_i == LW'(l))) begin
          w_alloc_hit[e*NUM_LANES + l] = 1'b1;
        end
      end
    end
  end

  // Per-lane next state; commit takes priority over flush, and illegal
  // alloc/commit requests leave the lane untouched but raise an error.
  always_comb begin
    w_err_nxt     = r_err;
    w_busy_nxt    = '0;
    w_release_nxt = '0;
    w_lane_err    = '0;
    for (int i = 0; i < NL; i++) begin
      w_next[i]     = r_state[i];
      w_lane_err[i] = w_commit_multi[i];
      case (r_state[i])
        S_FREE: begin
          if (w_commit_hit[i]) w_lane_err[i] = 1'b1;
          if (w_alloc_hit[i])  w_next[i] = S_ALLOC;
        end
        S_ALLOC: begin
          if (w_alloc_hit[i]) w_lane_err[i] = 1'b1;
          if (w_commit_hit[i]) begin
            w_next[i] = bus.lane_done_i[i] ? S_RELEASE : S_COMMITTED;
          end else if (bus.flush_i) begin
            w_next[i] = S_RELEASE;
          end else if (bus.lane_done_i[i]) begin
            w_next[i] = S_DONE_EARLY;
          end
        end
        S_DONE_EARLY: begin
          if (w_alloc_hit[i]) w_lane_err[i] = 1'b1;
          if (w_commit_hit[i] || bus.flush_i) w_next[i] = S_RELEASE;
        end
        S_COMMITTED: begin
          if (w_alloc_hit[i] || w_commit_hit[i]) w_lane_err[i] = 1'b1;
          if (bus.lane_done_i[i]) w_next[i] = S_RELEASE;
        end
        S_RELEASE: begin
          if (w_alloc_hit[i] || w_commit_hit[i]) w_lane_err[i] = 1'b1;
          w_next[i] = S_FREE;
        end
        default: w_next[i] = S_FREE;
      endcase
      w_release_nxt[i] = (w_next[i] == S_RELEASE);
      if (w_next[i] != S_FREE) w_busy_nxt = w_busy_nxt + CW'(1);
    end
    if (|w_lane_err) w_err_nxt = 1'b1;
  end

  // Lane FSMs and their registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NL; i++) r_state[i] <= S_FREE;
      r_reset_monitor <= '0;
      r_busy_cnt      <= '0;
      r_err           <= 1'b0;
    end else begin
      for (int i = 0; i < NL; i++) r_state[i] <= w_next[i];
      r_reset_monitor <= w_release_nxt;
      r_busy_cnt      <= w_busy_nxt;
      r_err           <= w_err_nxt;
    end
  end

  assign bus.reset_monitor_o = r_reset_monitor;
  assign bus.busy_cnt_o      = r_busy_cnt;
  assign bus.err_o           = r_err;
endmodule

// File: doc/rm_lane_release.md
RM_LANE_RELEASE -- requirements
Module: rm_lane_release

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, monitor lanes per event.
REQ-002 SHALL have parameter NUM_EVENTS, default 2, monitored event classes.
REQ-003 SHALL have parameter NR_COMMIT_PORTS, default 2, commit ports.
REQ-004 SHALL have ports (LW = clog2(NUM_LANES), EW = clog2(NUM_EVENTS), P = NR_COMMIT_PORTS):
- clk_i  in  1  single clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush
- alloc_valid_i  in  1  allocator granted a lane this cycle
- alloc_event_i  in  EW  event of granted lane
- alloc_lane_i  in  LW  granted lane index
- commit_ack_i  in  P  instruction on port p commits
- commit_rm_valid_i  in  P  committing instruction owns a lane
- commit_event_i  in  P*EW  event per port
- commit_lane_i  in  P*LW  lane per port
- lane_done_i  in  NUM_EVENTS*NUM_LANES  monitor lane finished its check (level)
- reset_monitor_o  out  NUM_EVENTS*NUM_LANES  one-cycle lane-release pulse, index e*NUM_LANES+l
- busy_cnt_o  out  clog2(NUM_EVENTS*NUM_LANES+1)  lanes not FREE
- err_o  out  1  sticky protocol-violation flag

Function
REQ-005 SHALL hold one FSM per (event, lane): FREE, ALLOC, DONE_EARLY, COMMITTED, RELEASE.
REQ-006 FREE -> ALLOC when alloc_valid_i targets it and flush_i=0.
REQ-007 ALLOC -> COMMITTED on matching commit (ack & rm_valid, event, lane match) with lane_done_i=0; -> RELEASE on matching commit with lane_done_i=1.
REQ-008 ALLOC -> DONE_EARLY on lane_done_i=1 without commit; DONE_EARLY -> RELEASE on matching commit.
REQ-009 COMMITTED -> RELEASE when lane_done_i=1.
REQ-010 RELEASE -> FREE unconditionally after exactly one cycle.
REQ-011 reset_monitor_o bit SHALL be 1 iff that lane is in RELEASE (registered, no combinational path from inputs).
REQ-012 Latency: commit with done already high -> release pulse in the next cycle.
REQ-013 flush_i=1 with no matching commit: ALLOC and DONE_EARLY lanes -> RELEASE next cycle; COMMITTED lanes unaffected.
REQ-014 Commit and flush in same cycle: commit applied first, so that lane follows REQ-007/008, not REQ-013.
REQ-015 alloc_valid_i SHALL be ignored while flush_i=1.
REQ-016 Multiple commit ports matching the same lane in one cycle: treated as one commit, err_o set.
REQ-017 Alloc to a non-FREE lane: ignored, err_o set; FREE lane in RELEASE-exit cycle is not FREE (reuse earliest one cycle after pulse).
REQ-018 Commit to a FREE, COMMITTED or RELEASE lane: ignored, err_o set.
REQ-019 busy_cnt_o SHALL be the registered count of lanes not FREE, updated each cycle, never wraps (max NUM_EVENTS*NUM_LANES).
REQ-020 err_o SHALL stay 1 until reset; flush does not clear it.

Reset
REQ-021 On rst_ni low, asynchronously: all FSMs FREE, reset_monitor_o=0, busy_cnt_o=0, err_o=0.
REQ-022 Reset mid-operation discards all in-flight lanes without emitting release pulses.

Verification
REQ-023 alloc e0/l1; 3 cycles later commit port0 e0/l1 with done=1 -> reset_monitor_o[1] pulses 1 cycle next cycle; busy_cnt_o 1 -> 0.
REQ-024 alloc e1/l2; done=1 before commit -> DONE_EARLY, no pulse; commit port1 e1/l2 -> bit 6 pulses next cycle.
REQ-025 alloc e0/l0 and e0/l3; commit e0/l0 (done=0); flush -> bit 3 pulses next cycle, bit 0 waits; done on l0 -> bit 0 pulses; busy_cnt_o ends 0.
REQ-026 Same-cycle commit e0/l2 (done=1) and flush -> single pulse on bit 2, err_o=0.
REQ-027 alloc e0/l0 twice without release; commit to FREE e1/l0 -> err_o=1 and stays 1 after flush; busy_cnt_o=1.
REQ-028 Fill all 8 lanes, assert rst_ni low mid-run -> all outputs 0 immediately, no pulses after release of reset.
